// File: rtl/fp_norm_pack_pkg.sv
// fp_norm_pack_pkg: shared widths, constants and FSM encoding for the FP
// normalize/round/pack back end.
//   IN_W       raw mantissa width: [28:27] headroom, [26] hidden, [25:3] frac, [2:0] G/R/S
//   EXP_W      signed biased internal exponent width
//   FRAC_W     packed fraction width
// Build option: ROUND_NEAREST_EN selects RNE rounding (default truncation).
package fp_norm_pack_pkg;
  localparam int IN_W       = 29;
  localparam int EXP_W      = 10;
  localparam int FRAC_W     = 23;
  localparam int GRS_W      = 3;
  localparam int EXP_BIAS   = 127;
  localparam int EXP_MAX    = 255;
  localparam int HIDDEN_POS = 26;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef logic        [IN_W-1:0]  mant_t;
  typedef logic signed [EXP_W-1:0] exp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_PACK  = 2'd3
  } state_e;
endpackage

// File: rtl/fp_norm_pack_if.sv
// fp_norm_pack_if: request/result bundle of the FP normalize/round/pack unit.
//   start, sign_i, exp_i, mant_i   request side (driven by the master)
//   busy, done, result, ovf, unf   status/result side (driven by the slave)
interface fp_norm_pack_if;
  import fp_norm_pack_pkg::*;

  logic        start;
  logic        sign_i;
  exp_t        exp_i;
  mant_t       mant_i;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic        unf;

  modport master (
    output start, sign_i, exp_i, mant_i,
    input  busy, done, result, ovf, unf
  );

  modport slave (
    input  start, sign_i, exp_i, mant_i,
    output busy, done, result, ovf, unf
  );
endinterface

// File: rtl/fp_norm_pack_round_rne.sv
// fp_norm_pack_round_rne: combinational rounding of a normalized extended
// mantissa (hidden bit at 26) to the 23-bit fraction at [25:3].
//   mant_i/exp_i   normalized mantissa and signed biased exponent
//   mant_o/exp_o   rounded mantissa and exponent, renormalized on carry
// Build option: ROUND_NEAREST_EN -> round-to-nearest-even on lsb=m[3],
// G=m[2], R|S=m[1]|m[0]; otherwise a pass-through (truncation, G/R/S ignored).
module fp_norm_pack_round_rne
  import fp_norm_pack_pkg::*;
(
  input  mant_t mant_i,
  input  exp_t  exp_i,
  output mant_t mant_o,
  output exp_t  exp_o
);
`ifdef ROUND_NEAREST_EN
  function automatic logic rne_up(input mant_t m);
    return m[GRS_W-1] & (m[GRS_W-2] | m[GRS_W-3] | m[GRS_W]);
  endfunction

  mant_t sum;

  always_comb begin
    sum = mant_i;
    if (rne_up(mant_i)) begin
      sum = mant_i + (mant_t'(1) << GRS_W);
    end
    mant_o = sum;
    exp_o  = exp_i;
    // All-ones fraction rounding up carries into bit 27: renormalize now.
    if (sum[HIDDEN_POS+1]) begin
      mant_o = sum >> 1;
      exp_o  = exp_i + exp_t'(1);
    end
  end
`else
  assign mant_o = mant_i;
  assign exp_o  = exp_i;
`endif
endmodule

// File: rtl/fp_norm_pack.sv
// fp_norm_pack: back end of the FP datapath. Takes a raw extended result
// (sign, 29-bit mantissa, signed biased exponent), normalizes it one bit per
// cycle, rounds, detects overflow/underflow and emits a packed IEEE-754 single.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-low
//   bus     fp_norm_pack_if.slave: start/sign_i/exp_i/mant_i in;
//           busy/done/result/ovf/unf out (all registered)
// Build option: ROUND_NEAREST_EN selects RNE rounding; undefined truncates.
// Latency is the same in both builds.
module fp_norm_pack
  import fp_norm_pack_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fp_norm_pack_if.slave bus
);
  localparam exp_t EXP_ONE  = exp_t'(1);
  localparam exp_t EXP_ZERO = exp_t'(0);
  localparam exp_t EXP_SAT  = exp_t'(EXP_MAX);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;

  logic        sign_q, sign_d;
  exp_t        exp_q, exp_d;
  mant_t       mant_q, mant_d;

  mant_t       rnd_mant;
  exp_t        rnd_exp;

  fp_norm_pack_round_rne u_round (
    .mant_i (mant_q),
    .exp_i  (exp_q),
    .mant_o (rnd_mant),
    .exp_o  (rnd_exp)
  );

  function automatic logic [31:0] pack_word(input logic s, input logic z, input exp_t e,
                                            input mant_t m);
    if (z)                   return {s, ZERO[30:0]};
    else if (e >= EXP_SAT)   return {s, INF[30:0]};
    else if (e <= EXP_ZERO)  return {s, ZERO[30:0]};
    else                     return {s, e[7:0], m[HIDDEN_POS-1:GRS_W]};
  endfunction

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    zero_d   = zero_q;
    result_d = result_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;

    case (state_q)
      ST_IDLE: begin
        // busy_q is still high in the done cycle, so a start there is ignored.
        if (bus.start && !busy_q) begin
          sign_d  = bus.sign_i;
          exp_d   = bus.exp_i;
          mant_d  = bus.mant_i;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        if (mant_q == '0) begin
          zero_d  = 1'b1;
          state_d = ST_PACK;
        end else if (mant_q[HIDDEN_POS+2] | mant_q[HIDDEN_POS+1]) begin
          // Right shift keeps the dropped bit as sticky in bit 0.
          mant_d = {1'b0, mant_q[IN_W-1:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + EXP_ONE;
        end else if (!mant_q[HIDDEN_POS]) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        mant_d  = rnd_mant;
        exp_d   = rnd_exp;
        state_d = ST_PACK;
      end

      ST_PACK: begin
        result_d = pack_word(sign_q, zero_q, exp_q, mant_q);
        if (!zero_q && exp_q >= EXP_SAT) begin
          ovf_d = 1'b1;
        end else if (!zero_q && exp_q <= EXP_ZERO) begin
          unf_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // control and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= ZERO;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      zero_q   <= zero_d;
      result_q <= result_d;
    end
  end

  // working datapath registers
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    mant_q <= mant_d;
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.unf    = unf_q;
endmodule
